// File: rtl/fc_argmax_seq.sv
// Sequential argmax over one captured vector of unsigned post-ReLU neuron scores.
// The vector is captured in one cycle, scanned one score per cycle, and the result is offered over valid/ready.
module fc_argmax_seq #(
  parameter int IN_WIDTH  = 23,
  parameter int N_CLASS   = 10,
  localparam int IDX_WIDTH = ($clog2(N_CLASS) > 1) ? $clog2(N_CLASS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_CLASS*IN_WIDTH-1:0]  in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [IDX_WIDTH-1:0]         out_class,
  output logic [IN_WIDTH-1:0]          out_score,
  output logic                         out_zero,
  output logic                         busy
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                        state_reg, state_next;
  logic [N_CLASS*IN_WIDTH-1:0]   cap_reg, cap_next;
  logic [IN_WIDTH-1:0]           best_reg, best_next;
  logic [IDX_WIDTH-1:0]          idx_reg, idx_next;
  logic [IDX_WIDTH-1:0]          cnt_reg, cnt_next;
  logic [IDX_WIDTH-1:0]          oclass_reg, oclass_next;
  logic [IN_WIDTH-1:0]           oscore_reg, oscore_next;
  logic                          ozero_reg, ozero_next;

  logic [IN_WIDTH-1:0]           score [N_CLASS];
  logic [IN_WIDTH-1:0]           cur_score;
  logic                          better;
  logic [IN_WIDTH-1:0]           scan_best;
  logic [IDX_WIDTH-1:0]          scan_idx;

  genvar gi;
  generate
    for (gi = 0; gi < N_CLASS; gi++) begin : g_split
      assign score[gi] = cap_reg[gi*IN_WIDTH +: IN_WIDTH];
    end
  endgenerate

  // Strict compare: on a tie the earlier (lower) index is kept.
  assign cur_score = score[cnt_reg];
  assign better    = (cur_score > best_reg);
  assign scan_best = better ? cur_score : best_reg;
  assign scan_idx  = better ? cnt_reg : idx_reg;

  always_comb begin
    state_next  = state_reg;
    cap_next    = cap_reg;
    best_next   = best_reg;
    idx_next    = idx_reg;
    cnt_next    = cnt_reg;
    oclass_next = oclass_reg;
    oscore_next = oscore_reg;
    ozero_next  = ozero_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          cap_next  = in_data;
          best_next = in_data[IN_WIDTH-1:0];
          idx_next  = '0;
          cnt_next  = IDX_WIDTH'(1);
          if (N_CLASS == 1) begin
            state_next  = DONE;
            oclass_next = '0;
            oscore_next = in_data[IN_WIDTH-1:0];
            ozero_next  = (in_data[IN_WIDTH-1:0] == '0);
          end else begin
            state_next = SCAN;
          end
        end
      end
      SCAN: begin
        best_next = scan_best;
        idx_next  = scan_idx;
        cnt_next  = cnt_reg + 1'b1;
        if (cnt_reg == IDX_WIDTH'(N_CLASS - 1)) begin
          state_next  = DONE;
          oclass_next = scan_idx;
          oscore_next = scan_best;
          ozero_next  = (scan_best == '0);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cap_reg    <= '0;
      best_reg   <= '0;
      idx_reg    <= '0;
      cnt_reg    <= '0;
      oclass_reg <= '0;
      oscore_reg <= '0;
      ozero_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cap_reg    <= cap_next;
      best_reg   <= best_next;
      idx_reg    <= idx_next;
      cnt_reg    <= cnt_next;
      oclass_reg <= oclass_next;
      oscore_reg <= oscore_next;
      ozero_reg  <= ozero_next;
    end
  end

  // Handshake flags decode the state register only, so no in_* to out_* path exists.
  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign out_class = oclass_reg;
  assign out_score = oscore_reg;
  assign out_zero  = ozero_reg;

endmodule

// File: tb/tb_fc_argmax_seq.sv
// Self-checking bench for fc_argmax_seq: vector table plus directed sequences,
// with a scoreboard queue filled on input accept and drained on output handshake.
module tb_fc_argmax_seq;

  localparam int W = 23;
  localparam int N = 10;

  typedef logic [W-1:0] vec_arr_t [N];
  typedef struct packed {
    logic [3:0]   cls;
    logic [W-1:0] score;
    logic         zero;
  } res_t;
  typedef struct {
    vec_arr_t s;
    res_t     exp;
  } tv_t;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [3:0]     out_class;
  logic [W-1:0]   out_score;
  logic           out_zero;
  logic           busy;

  fc_argmax_seq #(.IN_WIDTH(W), .N_CLASS(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_score (out_score),
    .out_zero  (out_zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors;
  int   checks;
  int   cyc;
  int   acc_cnt;
  int   last_acc;
  int   prev_acc;
  res_t pend_exp;
  res_t sb_q[$];
  tv_t  tbl[6];

  function automatic logic [N*W-1:0] pack(input vec_arr_t s);
    logic [N*W-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*W +: W] = s[k];
    return v;
  endfunction

  // Reference argmax: first index holding the largest value.
  function automatic res_t model(input vec_arr_t s);
    res_t r;
    r.cls   = 4'd0;
    r.score = s[0];
    for (int k = 1; k < N; k++) begin
      if (s[k] > r.score) begin
        r.score = s[k];
        r.cls   = 4'(k);
      end
    end
    r.zero = (r.score == '0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: monitor at the falling edge, then return #1 after the rising edge.
  task automatic step();
    res_t e;
    @(negedge clk);
    if (rst_n && in_valid && in_ready) begin
      sb_q.push_back(pend_exp);
      prev_acc = last_acc;
      last_acc = cyc;
      acc_cnt++;
    end
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got class=%0d score=0x%0h, expected no result", out_class, out_score);
      end else begin
        e = sb_q.pop_front();
        $display("out: class=%0d score=0x%0h zero=%0b (cycle %0d)", out_class, out_score, out_zero, cyc);
        chk("sb_class", 32'(out_class), 32'(e.cls));
        chk("sb_score", 32'(out_score), 32'(e.score));
        chk("sb_zero",  32'(out_zero),  32'(e.zero));
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic send_vec(input vec_arr_t s, input res_t e);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    in_data  = pack(s);
    pend_exp = e;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 60) begin
      step();
      n++;
    end
  endtask

  initial begin
    vec_arr_t v;
    res_t     r;
    int       lat;
    int       a0;
    bit       switched;

    errors = 0; checks = 0; cyc = 0; acc_cnt = 0; last_acc = 0; prev_acc = 0;
    pend_exp = '0;

    tbl[0].s = '{23'd5, 23'd9, 23'd3, 23'd0, 23'd0, 23'd0, 23'd0, 23'd0, 23'd0, 23'd0};
    tbl[0].exp = '{4'd1, 23'd9, 1'b0};
    tbl[1].s = '{23'd1, 23'd2, 23'h3FFFFF, 23'd4, 23'd5, 23'd6, 23'd7, 23'h3FFFFF, 23'd8, 23'd9};
    tbl[1].exp = '{4'd2, 23'h3FFFFF, 1'b0};
    tbl[2].s = '{23'd0, 23'd0, 23'd0, 23'd0, 23'd0, 23'd0, 23'd0, 23'd0, 23'd0, 23'd0};
    tbl[2].exp = '{4'd0, 23'd0, 1'b1};
    tbl[3].s = '{23'd0, 23'd3, 23'd6, 23'd9, 23'd12, 23'd15, 23'd18, 23'd21, 23'd24, 23'd1000};
    tbl[3].exp = '{4'd9, 23'd1000, 1'b0};
    tbl[4].s = '{23'd77, 23'd1, 23'd76, 23'd2, 23'd3, 23'd4, 23'd5, 23'd6, 23'd7, 23'd77};
    tbl[4].exp = '{4'd0, 23'd77, 1'b0};
    tbl[5].s = '{23'd0, 23'd0, 23'd0, 23'd0, 23'd0, 23'd1, 23'd0, 23'd0, 23'd0, 23'd0};
    tbl[5].exp = '{4'd5, 23'd1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_class", 32'(out_class), 32'd0);
    chk("rst_out_score", 32'(out_score), 32'd0);
    chk("rst_out_zero",  32'(out_zero),  32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    rst_n = 1'b1;
    step();

    // Table vectors, consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send_vec(tbl[i].s, tbl[i].exp);
      chk("scan_in_ready", 32'(in_ready), 32'd0);
      chk("scan_busy",     32'(busy),     32'd1);
      wait_out(lat);
      chk("latency", 32'(lat), 32'(N - 1));
      step();
      chk("valid_drop", 32'(out_valid), 32'd0);
    end

    // Result held in DONE while the consumer stalls; a second vector is ignored.
    out_ready = 1'b0;
    v = '{23'd1, 23'd2, 23'd3, 23'd4, 23'd100, 23'd6, 23'd7, 23'd8, 23'd9, 23'd10};
    send_vec(v, '{4'd4, 23'd100, 1'b0});
    wait_out(lat);
    chk("hold_latency", 32'(lat), 32'(N - 1));
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        v = '{23'd500, 23'd0, 23'd0, 23'd0, 23'd0, 23'd0, 23'd0, 23'd0, 23'd0, 23'd0};
        in_data  = pack(v);
        pend_exp = model(v);
        in_valid = 1'b1;
      end
      if (i == 9) in_valid = 1'b0;
      step();
      chk("hold_outputs", {2'b00, out_valid, in_ready, out_class, out_score, out_zero},
          {2'b00, 1'b1, 1'b0, 4'd4, 23'd100, 1'b0});
    end
    out_ready = 1'b1;
    step();
    chk("hold_release", 32'(out_valid), 32'd0);
    repeat (12) step();
    chk("ignored_no_output", 32'(out_valid), 32'd0);
    chk("ignored_queue_empty", 32'(sb_q.size()), 32'd0);

    // Reset in the middle of a scan discards the transaction.
    send_vec(tbl[0].s, tbl[0].exp);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy",      32'(busy),      32'd0);
    sb_q.delete();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("midrst_no_valid", 32'(out_valid), 32'd0);
    end
    v = '{23'd4, 23'd8, 23'd15, 23'd16, 23'd23, 23'd42, 23'd7, 23'd1, 23'd2, 23'h3FFFFF};
    send_vec(v, '{4'd9, 23'h3FFFFF, 1'b0});
    wait_out(lat);
    chk("midrst_latency", 32'(lat), 32'(N - 1));
    step();

    // Back-to-back vectors with in_valid held high.
    a0 = acc_cnt;
    switched = 1'b0;
    in_data  = pack(tbl[1].s);
    pend_exp = tbl[1].exp;
    in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (!switched && acc_cnt == a0 + 1) begin
        in_data  = pack(tbl[3].s);
        pend_exp = tbl[3].exp;
        switched = 1'b1;
      end
      if (acc_cnt == a0 + 2) break;
    end
    in_valid = 1'b0;
    chk("b2b_accepts", 32'(acc_cnt - a0), 32'd2);
    chk("b2b_spacing", 32'(last_acc - prev_acc), 32'(N + 1));

    // A few random vectors against the reference model; narrow ranges force ties.
    for (int r_i = 0; r_i < 4; r_i++) begin
      for (int k = 0; k < N; k++)
        v[k] = (r_i % 2 == 0) ? W'($urandom_range(0, 15)) : W'($urandom_range(0, 23'h3FFFFF));
      r = model(v);
      send_vec(v, r);
      wait_out(lat);
      chk("rand_latency", 32'(lat), 32'(N - 1));
      step();
    end

    for (int i = 0; i < 40 && sb_q.size() != 0; i++) step();
    chk("drain_queue_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
